// File: rtl/alu_div8b_pkg.sv
// Shared definitions for the sequential restoring divider.
package alu_div8b_pkg;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Quotient reported on divide-by-zero: all ones, truncated to the datapath width at use
    localparam int unsigned DIVZ_QUO_W = 64;
    localparam logic [DIVZ_QUO_W-1:0] DIVZ_QUO = '1;

endpackage

// File: rtl/add8b.sv
// Ripple-style adder with carry-in/carry-out; used in subtract mode by the divider.
module add8b #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum_c,
    output logic             cout_c
);

    logic [WIDTH:0] full_c;

    // Full-width sum keeps the carry-out as the extra top bit
    always_comb begin
        full_c = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sum_c  = full_c[WIDTH-1:0];
        cout_c = full_c[WIDTH];
    end

endmodule

// File: rtl/alu_div8b.sv
// Sequential restoring unsigned divider: one quotient bit per clock, start/done handshake.
module alu_div8b
    import alu_div8b_pkg::*;
#(
    parameter int unsigned DATASIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iStart,
    input  logic [DATASIZE-1:0] iDvd,
    input  logic [DATASIZE-1:0] iDvs,
    output logic [DATASIZE-1:0] oQuo,
    output logic [DATASIZE-1:0] oRem,
    output logic                oBusy,
    output logic                oDone,
    output logic                oDivZ
);

    localparam int unsigned CNT_W = $clog2(DATASIZE);
    localparam int unsigned REM_W = DATASIZE + 1;

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATASIZE-1:0] dvd_q, dvd_d;
    logic [DATASIZE-1:0] dvs_q, dvs_d;
    logic [DATASIZE-1:0] rem_q, rem_d;
    logic [DATASIZE-1:0] quo_q, quo_d;
    logic [DATASIZE-1:0] quo_out_d, rem_out_d;
    logic                divz_d, busy_d, done_d;

    logic [REM_W-1:0]    r_shift_c;
    logic [REM_W-1:0]    dvs_inv_c;
    logic [REM_W-1:0]    trial_sum_c;
    logic                trial_cout_c;
    logic [DATASIZE-1:0] quo_shift_c;
    logic                unused_c;

    // Shifted partial remainder and inverted divisor feeding the trial subtraction
    always_comb begin
        r_shift_c   = {rem_q, dvd_q[DATASIZE-1]};
        dvs_inv_c   = ~{1'b0, dvs_q};
        quo_shift_c = {quo_q[DATASIZE-2:0], trial_cout_c};
    end

    // Restored remainder is always below the divisor, so the trial MSB and the quotient
    // bit shifted out of the top are never needed
    assign unused_c = ^{trial_sum_c[DATASIZE], quo_q[DATASIZE-1]};

    add8b #(
        .WIDTH (REM_W)
    ) u_sub (
        .a      (r_shift_c),
        .b      (dvs_inv_c),
        .cin    (1'b1),
        .sum_c  (trial_sum_c),
        .cout_c (trial_cout_c)
    );

    // Next-state, datapath and registered-output values
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        quo_out_d = oQuo;
        rem_out_d = oRem;
        divz_d    = oDivZ;

        case (state_q)
            IDLE: begin
                if (iStart) begin
                    dvd_d = iDvd;
                    dvs_d = iDvs;
                    rem_d = '0;
                    quo_d = '0;
                    cnt_d = '0;
                    if (iDvs != '0) begin
                        state_d = CALC;
                    end else begin
                        state_d   = DONE;
                        quo_out_d = DATASIZE'(DIVZ_QUO);
                        rem_out_d = iDvd;
                        divz_d    = 1'b1;
                    end
                end
            end
            CALC: begin
                dvd_d = {dvd_q[DATASIZE-2:0], 1'b0};
                rem_d = trial_cout_c ? trial_sum_c[DATASIZE-1:0] : r_shift_c[DATASIZE-1:0];
                quo_d = quo_shift_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATASIZE - 1)) begin
                    state_d   = DONE;
                    quo_out_d = quo_shift_c;
                    rem_out_d = rem_d;
                    divz_d    = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            oQuo    <= '0;
            oRem    <= '0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oDivZ   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            oQuo    <= quo_out_d;
            oRem    <= rem_out_d;
            oBusy   <= busy_d;
            oDone   <= done_d;
            oDivZ   <= divz_d;
        end
    end

endmodule

// File: doc/alu_div8b.md
Name: alu_div8b

Overview:
- Sequential restoring unsigned divider for the core85 ALU datapath.
- It is the inverse operation of the adder: it repeatedly performs trial subtraction, using the existing add8b adder in subtract mode (inverted operand, carry-in 1).
- Produces one quotient bit per clock.
- Sits beside the combinational ALU and serves multi-cycle divide micro-ops under a start/done handshake.

Parameters:
- DATASIZE, 8, operand/quotient/remainder width in bits (must be >= 2).

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst  input  1  synchronous active-high reset
- iStart  input  1  request a division; sampled only in IDLE
- iDvd  input  DATASIZE  dividend, captured on the accepted start edge
- iDvs  input  DATASIZE  divisor, captured on the accepted start edge
- oQuo  output  DATASIZE  quotient, valid when oDone=1 and held until the next accepted start
- oRem  output  DATASIZE  remainder, valid and held under the same rule as oQuo
- oBusy  output  1  high whenever state is not IDLE
- oDone  output  1  single-cycle pulse marking result valid
- oDivZ  output  1  divide-by-zero flag, held with the results

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): state=IDLE, step counter=0; oQuo, oRem, oBusy, oDone, oDivZ all 0. Reset wins over every other event, including mid-CALC; a partial result is discarded.
- States: IDLE, CALC, DONE.
- IDLE: iStart=1 at edge N latches iDvd/iDvs and clears the partial remainder R (DATASIZE+1 bits) and the counter.
  - If iDvs!=0: state->CALC.
  - If iDvs==0: state->DONE; oQuo=all ones, oRem=iDvd, oDivZ=1.
- IDLE with iStart=0: outputs hold their previous results.
- CALC step, one per edge:
  - R'={R[DATASIZE-1:0], dividend MSB}; shift the dividend register left.
  - T=R'-{0,divisor} via add8b at width DATASIZE+1 (B inverted, carry-in 1).
  - Carry-out=1 (no borrow): R=T, quotient bit=1. Otherwise R=R', quotient bit=0.
  - The quotient shifts in from the LSB.
  - After DATASIZE steps (edge N+DATASIZE): state->DONE; oQuo=quotient, oRem=R[DATASIZE-1:0], oDivZ=0.
- DONE: oDone=1 for exactly one cycle; next edge->IDLE unconditionally.
- Latency: normal division gives oDone high in the cycle after edge N+DATASIZE (9 cycles for DATASIZE=8). Divide-by-zero gives oDone in the cycle after edge N.
- iStart while oBusy=1 (CALC or DONE) is ignored, with no queueing. iStart held high re-triggers on the first IDLE cycle after DONE.
- Operand inputs are don't-care outside the start edge; changes during CALC have no effect.
- Results are unsigned. No overflow is possible except divide-by-zero. Boundaries: 0/x gives 0 r0; x/1 gives x r0; x<divisor gives 0 r x.

Decomposition:
- Shared package: state encoding constants (IDLE/CALC/DONE) and the divide-by-zero quotient constant (all ones). No typedefs beyond these.
- One sub-module: add8b, instantiated with DATASIZE+1 as the trial subtractor.
- Counter, shift registers and FSM stay in alu_div8b.

Test Plan:
- 200/7 with start at edge N -> oDone high after edge N+8, oQuo=28, oRem=4, oDivZ=0; oBusy high from edge N to edge N+8 inclusive.
- 255/1 -> 255 r0. 5/9 -> 0 r5. 0/3 -> 0 r0. 255/255 -> 1 r0.
- 77/0 -> oDone in the cycle after the start edge, oQuo=255, oRem=77, oDivZ=1; a following 10/3 gives 3 r1 and clears oDivZ.
- Second iStart (100/10) asserted mid-CALC of 200/7 -> ignored; result is 28 r4, with exactly one oDone pulse.
- rst asserted 3 cycles into a CALC -> all outputs 0, state IDLE next cycle; a fresh 9/2 then gives 4 r1 with correct latency.
- Exhaustive sweep of all dividend/divisor pairs (divisor!=0) against a behavioural model -> zero mismatches. Held iStart -> back-to-back operations spaced DATASIZE+2 cycles apart.
